// File: rtl/fetch_decode_pkg.sv
// Shared constants and instruction-field helpers for the fetch/decode front end.
// Instruction layout, MSB first: {opcode[OPC_W-1:0], rd, rs1, rs2}, each register
// field RA_W bits wide.
package fetch_decode_pkg;

    localparam int unsigned OPC_W       = 4;
    // Upper bounds for the helper functions; REG_N up to 256 fits in these.
    localparam int unsigned MAX_RA_W    = 8;
    localparam int unsigned MAX_INSTR_W = 32;

    // Total instruction width for a given register-address width.
    function automatic int unsigned instr_width(input int unsigned ra_w);
        return OPC_W + 3 * ra_w;
    endfunction

    // Extract an ra_w-bit field starting at bit lsb of a zero-extended instruction.
    function automatic logic [MAX_RA_W-1:0] field_at(input logic [MAX_INSTR_W-1:0] instr,
                                                     input int unsigned lsb,
                                                     input int unsigned ra_w);
        logic [MAX_INSTR_W-1:0] sh;
        sh = (instr >> lsb) & ((MAX_INSTR_W'(1) << ra_w) - MAX_INSTR_W'(1));
        return sh[MAX_RA_W-1:0];
    endfunction

    function automatic logic [OPC_W-1:0] field_opc(input logic [MAX_INSTR_W-1:0] instr,
                                                   input int unsigned ra_w);
        logic [MAX_INSTR_W-1:0] sh;
        sh = instr >> (3 * ra_w);
        return sh[OPC_W-1:0];
    endfunction

    function automatic logic [MAX_RA_W-1:0] field_rd(input logic [MAX_INSTR_W-1:0] instr,
                                                     input int unsigned ra_w);
        return field_at(instr, 2 * ra_w, ra_w);
    endfunction

    function automatic logic [MAX_RA_W-1:0] field_rs1(input logic [MAX_INSTR_W-1:0] instr,
                                                      input int unsigned ra_w);
        return field_at(instr, ra_w, ra_w);
    endfunction

    function automatic logic [MAX_RA_W-1:0] field_rs2(input logic [MAX_INSTR_W-1:0] instr,
                                                      input int unsigned ra_w);
        return field_at(instr, 0, ra_w);
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_regfile.sv
// Register file with hardwired zero register, two combinational read ports,
// one synchronous write port and write-back bypass onto both read ports.
// Ports: clk, reset (async active-low), we/waddr/wdata write port,
//        raddr1/raddr2 read addresses, rdata1/rdata2 read data.
module regfile_bypass #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned REG_N  = 16,
    localparam int unsigned RA_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr1,
    input  logic [RA_W-1:0]   raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [REG_N];

    // Storage; register 0 is never written so it stays zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: zero register first, then same-cycle write-back, then storage.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch/decode front end: PC, loadable instruction memory, IF/ID register with
// valid/ready handshake, branch redirect/flush, and decoded operand read.
// Ports: clk, reset (async active-low), run (fetch enable),
//        imem_we/imem_waddr/imem_wdata (instruction load), br_valid/br_target
//        (redirect), wb_we/wb_addr/wb_data (register write-back), id_ready
//        (execute accepts); outputs pc, id_valid, id_pc, id_opcode, id_rd,
//        id_rs1_data, id_rs2_data.
module fetch_decode_pipe
    import fetch_decode_pkg::*;
#(
    parameter  int unsigned DATA_W     = 16,
    parameter  int unsigned REG_N      = 16,
    parameter  int unsigned IMEM_DEPTH = 64,
    localparam int unsigned RA_W       = $clog2(REG_N),
    localparam int unsigned PC_W       = $clog2(IMEM_DEPTH),
    localparam int unsigned INSTR_W    = instr_width(RA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    input  logic               wb_we,
    input  logic [RA_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               id_ready,
    output logic [PC_W-1:0]    pc,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [OPC_W-1:0]   id_opcode,
    output logic [RA_W-1:0]    id_rd,
    output logic [DATA_W-1:0]  id_rs1_data,
    output logic [DATA_W-1:0]  id_rs2_data
);

    logic [INSTR_W-1:0]     imem [IMEM_DEPTH];
    logic [INSTR_W-1:0]     id_instr;
    logic [MAX_INSTR_W-1:0] instr_ext;
    logic [RA_W-1:0]        rs1;
    logic [RA_W-1:0]        rs2;
    logic                   stall;

    assign stall = id_valid & ~id_ready;

    // Instruction memory load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Program counter: redirect beats sequential fetch; wraps naturally at PC_W bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (br_valid) begin
            pc <= br_target;
        end else if (run && !stall) begin
            pc <= pc + PC_W'(1);
        end
    end

    // IF/ID register: a redirect flushes even while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (br_valid) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_valid <= run;
            id_pc    <= pc;
            id_instr <= imem[pc];
        end
    end

    // Field decode straight from the held IF/ID word.
    assign instr_ext = MAX_INSTR_W'(id_instr);
    assign id_opcode = field_opc(instr_ext, RA_W);
    assign id_rd     = RA_W'(field_rd(instr_ext, RA_W));
    assign rs1       = RA_W'(field_rs1(instr_ext, RA_W));
    assign rs2       = RA_W'(field_rs2(instr_ext, RA_W));

    regfile_bypass #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (id_rs1_data),
        .rdata2 (id_rs2_data)
    );

endmodule
